// File: rtl/scroll_sequencer.sv
// Purpose: song scroll sequencer; fetches 32-note chunks and paces display shift strobes by tempo (optional SCROLL_FAST_EN adds a 'fast' halve-tempo input).
// Latency: load one cycle after the accepted chunk_valid; scroll one cycle after the step's final divider cycle.
// Backpressure: FETCH waits indefinitely for chunk_valid; pause freezes PLAY; start is ignored while busy.
module scroll_sequencer #(
  parameter int SONG_CHUNKS = 8,
  parameter int TEMPO_W     = 16,
  localparam int IDX_W      = $clog2(SONG_CHUNKS)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               pause,
  input  logic [TEMPO_W-1:0] tempo,
`ifdef SCROLL_FAST_EN
  input  logic               fast,
`endif
  output logic               chunk_req,
  output logic [IDX_W-1:0]   chunk_idx,
  input  logic               chunk_valid,
  input  logic [31:0]        chunk1,
  input  logic [31:0]        chunk2,
  output logic [31:0]        notes1,
  output logic [31:0]        notes2,
  output logic               load,
  output logic               scroll,
  output logic [4:0]         beat_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_CHUNKS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4:0]         beat_q, beat_d;
  logic [TEMPO_W-1:0] div_q, div_d;
  logic [31:0]        notes1_q, notes1_d;
  logic [31:0]        notes2_q, notes2_d;
  logic               load_q, load_d;
  logic               scroll_q, scroll_d;

  logic [TEMPO_W-1:0] eff_tempo;
  logic [TEMPO_W-1:0] step_limit;

  // Last divider value of a step: max(period,1)-1; '>=' in the FSM lets a shortened tempo fire at once.
  always_comb begin
    eff_tempo = tempo;
`ifdef SCROLL_FAST_EN
    if (fast) eff_tempo = tempo >> 1;
`endif
    step_limit = (eff_tempo == '0) ? '0 : eff_tempo - TEMPO_W'(1);
  end

  // State register and all datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      beat_q   <= '0;
      div_q    <= '0;
      notes1_q <= '0;
      notes2_q <= '0;
      load_q   <= 1'b0;
      scroll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      div_q    <= div_d;
      notes1_q <= notes1_d;
      notes2_q <= notes2_d;
      load_q   <= load_d;
      scroll_q <= scroll_d;
    end
  end

  // Next-state logic: song start, chunk fetch, tempo-paced stepping and chunk advance.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    div_d    = div_q;
    notes1_d = notes1_q;
    notes2_d = notes2_q;
    load_d   = 1'b0;
    scroll_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          beat_d  = '0;
          div_d   = '0;
        end
      end
      S_FETCH: begin
        // Only FETCH accepts chunk data; stray acks elsewhere leave notes untouched.
        if (chunk_valid) begin
          notes1_d = chunk1;
          notes2_d = chunk2;
          load_d   = 1'b1;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!pause) begin
          if (div_q >= step_limit) begin
            scroll_d = 1'b1;
            div_d    = '0;
            beat_d   = beat_q + 5'd1;
            // 32nd step of the chunk still scrolls, then moves on.
            if (beat_q == 5'd31) begin
              if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_FETCH;
              end
            end
          end else begin
            div_d = div_q + TEMPO_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign chunk_req = (state_q == S_FETCH);
  assign busy      = (state_q == S_FETCH) || (state_q == S_PLAY);
  assign done      = (state_q == S_DONE);
  assign chunk_idx = idx_q;
  assign beat_cnt  = beat_q;
  assign notes1    = notes1_q;
  assign notes2    = notes2_q;
  assign load      = load_q;
  assign scroll    = scroll_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Purpose: self-checking bench for scroll_sequencer against a song-position reference model.
// Latency: model and DUT both update on the rising edge; outputs are compared on the falling edge.
// Backpressure: the bench acts as song storage, acking chunk requests directly or at random.
module tb_scroll_sequencer;

  localparam int N  = 2;
  localparam int TW = 8;
  localparam int IW = $clog2(N);

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_DONE  = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [TW-1:0] tempo = '0;
`ifdef SCROLL_FAST_EN
  logic          fast = 1'b0;
`endif
  logic          chunk_valid = 1'b0;
  logic [31:0]   chunk1 = '0;
  logic [31:0]   chunk2 = '0;
  logic          chunk_req;
  logic [IW-1:0] chunk_idx;
  logic [31:0]   notes1, notes2;
  logic          load, scroll, busy, done;
  logic [4:0]    beat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  scroll_sequencer #(.SONG_CHUNKS(N), .TEMPO_W(TW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pause(pause), .tempo(tempo),
`ifdef SCROLL_FAST_EN
    .fast(fast),
`endif
    .chunk_req(chunk_req), .chunk_idx(chunk_idx), .chunk_valid(chunk_valid),
    .chunk1(chunk1), .chunk2(chunk2), .notes1(notes1), .notes2(notes2),
    .load(load), .scroll(scroll), .beat_cnt(beat_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the song is a sequence of 32*N steps; position is the step count,
  // and each step lasts max(period,1) un-paused PLAY cycles.
  int          m_phase = PH_IDLE;
  int          m_steps = 0;
  int          m_elapsed = 0;
  logic [31:0] m_n1 = '0, m_n2 = '0;
  bit          m_load = 0, m_scroll = 0;

  function automatic int step_period(input int t, input bit f);
    int p;
    p = f ? (t / 2) : t;
    return (p < 1) ? 1 : p;
  endfunction

  // Model update on each edge, or cleared by reset.
  always @(posedge clk or negedge n_rst) begin
    int ph, st, el;
    logic [31:0] a, b;
    bit ld, sc, f;
    if (!n_rst) begin
      m_phase <= PH_IDLE; m_steps <= 0; m_elapsed <= 0;
      m_n1 <= '0; m_n2 <= '0; m_load <= 0; m_scroll <= 0;
    end else begin
      ph = m_phase; st = m_steps; el = m_elapsed; a = m_n1; b = m_n2; ld = 0; sc = 0;
      f = 0;
`ifdef SCROLL_FAST_EN
      f = fast;
`endif
      case (ph)
        PH_IDLE, PH_DONE: if (start) begin ph = PH_FETCH; st = 0; el = 0; end
        PH_FETCH: if (chunk_valid) begin a = chunk1; b = chunk2; ld = 1; ph = PH_PLAY; end
        PH_PLAY: if (!pause) begin
          el = el + 1;
          if (el >= step_period(int'(tempo), f)) begin
            sc = 1; el = 0; st = st + 1;
            if (st % 32 == 0) ph = (st == 32 * N) ? PH_DONE : PH_FETCH;
          end
        end
        default: ;
      endcase
      m_phase <= ph; m_steps <= st; m_elapsed <= el;
      m_n1 <= a; m_n2 <= b; m_load <= ld; m_scroll <= sc;
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    int exp_idx;
    exp_idx = (m_phase == PH_DONE) ? (N - 1) : (m_steps / 32);
    check("chunk_req", 32'(chunk_req), 32'(m_phase == PH_FETCH));
    check("chunk_idx", 32'(chunk_idx), exp_idx);
    check("beat_cnt",  32'(beat_cnt), m_steps % 32);
    check("busy",      32'(busy), 32'(m_phase == PH_FETCH || m_phase == PH_PLAY));
    check("done",      32'(done), 32'(m_phase == PH_DONE));
    check("load",      32'(load), 32'(m_load));
    check("scroll",    32'(scroll), 32'(m_scroll));
    check("notes1",    notes1, m_n1);
    check("notes2",    notes2, m_n2);
    check("load_scroll_excl", 32'(load & scroll), 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int cyc, last, pulses, badint, extra, k;

    // Reset state.
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(chunk_req), 32'd0);
    check("rst_notes1", notes1, 32'd0);

    // First chunk fetch, acked two cycles after the request.
    n_rst = 1'b1; tempo = 8'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("fetch_req", 32'(chunk_req), 32'd1);
    check("fetch_idx", 32'(chunk_idx), 32'd0);
    repeat (2) @(negedge clk);
    chunk_valid = 1'b1; chunk1 = 32'hAAAAAAAA; chunk2 = 32'h0000FFFF;
    @(negedge clk); chunk_valid = 1'b0;
    check("load_pulse", 32'(load), 32'd1);
    check("notes1_aa", notes1, 32'hAAAAAAAA);
    check("play_busy", 32'(busy), 32'd1);
    check("play_req", 32'(chunk_req), 32'd0);

    // tempo=4: 32 scrolls every 4 cycles, then request chunk 1.
    cyc = 0; last = 0; pulses = 0; badint = 0; extra = 0;
    while (pulses < 32 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (load) extra++;
      if (scroll) begin
        pulses++;
        if (cyc - last != 4) badint++;
        last = cyc;
      end
    end
    check("t4_pulses", pulses, 32);
    check("t4_interval_errs", badint, 0);
    check("t4_single_load", extra, 0);
    check("t4_next_req", 32'(chunk_req), 32'd1);
    check("t4_next_idx", 32'(chunk_idx), 32'd1);

    // Pause for 10 cycles with the divider at 2; resume scrolls after 4-2 cycles.
    chunk_valid = 1'b1; chunk1 = 32'h13572468;
    @(negedge clk); chunk_valid = 1'b0;
    k = 0;
    while (!scroll && k < 20) begin @(negedge clk); k++; end
    check("pause_align_seen", 32'(scroll), 32'd1);
    repeat (2) @(negedge clk);
    pause = 1'b1; pulses = 0;
    repeat (10) begin @(negedge clk); if (scroll) pulses++; end
    check("pause_no_scroll", pulses, 0);
    pause = 1'b0; k = 0;
    do begin @(negedge clk); k++; end while (!scroll && k < 20);
    check("pause_resume_delay", k, 2);

    // Whole song at tempo=1: 64 scrolls, DONE, then restart.
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1; tempo = 8'd1; start = 1'b1;
    pulses = 0; cyc = 0;
    while (cyc < 500) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (scroll) pulses++;
      if (done) break;
      chunk_valid = chunk_req; chunk1 = $urandom; chunk2 = $urandom;
    end
    chunk_valid = 1'b0;
    check("song_pulses", pulses, 64);
    check("song_done", 32'(done), 32'd1);
    check("song_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart_req", 32'(chunk_req), 32'd1);
    check("restart_idx", 32'(chunk_idx), 32'd0);
    check("restart_done", 32'(done), 32'd0);

    // Reset mid-PLAY at beat 17; a late ack afterwards is ignored.
    tempo = 8'd2; chunk_valid = 1'b1; chunk1 = 32'hCAFEF00D;
    @(negedge clk); chunk_valid = 1'b0;
    k = 0;
    while (beat_cnt != 5'd17 && k < 200) begin @(negedge clk); k++; end
    check("beat17_reached", 32'(beat_cnt), 32'd17);
    #2 n_rst = 1'b0;
    #1;
    check("arst_req", 32'(chunk_req), 32'd0);
    check("arst_idx", 32'(chunk_idx), 32'd0);
    check("arst_notes1", notes1, 32'd0);
    check("arst_notes2", notes2, 32'd0);
    check("arst_load", 32'(load), 32'd0);
    check("arst_scroll", 32'(scroll), 32'd0);
    check("arst_beat", 32'(beat_cnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    n_rst = 1'b1; chunk_valid = 1'b1; chunk1 = 32'h12345678;
    @(negedge clk); chunk_valid = 1'b0;
    check("late_ack_notes1", notes1, 32'd0);
    check("late_ack_load", 32'(load), 32'd0);
    check("late_ack_busy", 32'(busy), 32'd0);

`ifdef SCROLL_FAST_EN
    // fast halves the period: tempo 8 -> 4 cycles, tempo 1 -> every cycle.
    fast = 1'b1; tempo = 8'd8; start = 1'b1;
    @(negedge clk); start = 1'b0; chunk_valid = 1'b1;
    @(negedge clk); chunk_valid = 1'b0;
    cyc = 0; last = 0; pulses = 0; badint = 0;
    while (pulses < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (scroll) begin pulses++; if (cyc - last != 4) badint++; last = cyc; end
    end
    check("fast_t8_pulses", pulses, 5);
    check("fast_t8_interval_errs", badint, 0);
    tempo = 8'd1; @(negedge clk);
    pulses = 0;
    repeat (5) begin @(negedge clk); if (scroll) pulses++; end
    check("fast_t1_pulses", pulses, 5);
    fast = 1'b0;
`endif

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) tempo = TW'($urandom_range(0, 5));
      chunk_valid = ($urandom_range(0, 2) == 0);
      chunk1 = $urandom; chunk2 = $urandom;
`ifdef SCROLL_FAST_EN
      if ($urandom_range(0, 49) == 0) fast = ~fast;
`endif
      n_rst = ($urandom_range(0, 999) != 0);
    end
    n_rst = 1'b1; start = 1'b0; chunk_valid = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
